exp_golomb_parser: RTL

EXP_GOLOMB_PARSER -- requirements
Module: exp_golomb_parser

---
 rtl/exp_golomb_pkg.sv | 69 ++++++
 rtl/exp_golomb_bitbuf.sv | 60 ++++++
 rtl/exp_golomb_parser.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/exp_golomb_pkg.sv
// Purpose : shared types and lookup tables for the Exp-Golomb syntax-element parser.
// Latency : n/a (types, constants and pure functions only).
// Backpr. : n/a.
// Contents: request mode encodings, parser FSM state type and the me(v)
//           codeNum -> coded_block_pattern tables (ChromaArrayType 1 or 2).
package exp_golomb_pkg;

  // Request modes; encodings 5..7 are reserved and decode as malformed.
  typedef enum logic [2:0] {
    MODE_UE = 3'd0,
    MODE_SE = 3'd1,
    MODE_TE = 3'd2,
    MODE_ME = 3'd3,
    MODE_UN = 3'd4
  } eg_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } eg_state_e;

  localparam int ME_MAX_CODE = 47;
  localparam int LEN_W       = 6;

  // codeNum -> coded_block_pattern for Intra_4x4 / Intra_8x8 macroblocks.
  // Result is {chroma[1:0], luma[3:0]}.
  function automatic logic [5:0] me_cbp_intra(input logic [5:0] code);
    logic [5:0] cbp;
    case (code)
      6'd0:  cbp = 6'd47;  6'd1:  cbp = 6'd31;  6'd2:  cbp = 6'd15;  6'd3:  cbp = 6'd0;
      6'd4:  cbp = 6'd23;  6'd5:  cbp = 6'd27;  6'd6:  cbp = 6'd29;  6'd7:  cbp = 6'd30;
      6'd8:  cbp = 6'd7;   6'd9:  cbp = 6'd11;  6'd10: cbp = 6'd13;  6'd11: cbp = 6'd14;
      6'd12: cbp = 6'd39;  6'd13: cbp = 6'd43;  6'd14: cbp = 6'd45;  6'd15: cbp = 6'd46;
      6'd16: cbp = 6'd16;  6'd17: cbp = 6'd3;   6'd18: cbp = 6'd5;   6'd19: cbp = 6'd10;
      6'd20: cbp = 6'd12;  6'd21: cbp = 6'd19;  6'd22: cbp = 6'd21;  6'd23: cbp = 6'd26;
      6'd24: cbp = 6'd28;  6'd25: cbp = 6'd35;  6'd26: cbp = 6'd37;  6'd27: cbp = 6'd42;
      6'd28: cbp = 6'd44;  6'd29: cbp = 6'd1;   6'd30: cbp = 6'd2;   6'd31: cbp = 6'd4;
      6'd32: cbp = 6'd8;   6'd33: cbp = 6'd17;  6'd34: cbp = 6'd18;  6'd35: cbp = 6'd20;
      6'd36: cbp = 6'd24;  6'd37: cbp = 6'd6;   6'd38: cbp = 6'd9;   6'd39: cbp = 6'd22;
      6'd40: cbp = 6'd25;  6'd41: cbp = 6'd32;  6'd42: cbp = 6'd33;  6'd43: cbp = 6'd34;
      6'd44: cbp = 6'd36;  6'd45: cbp = 6'd40;  6'd46: cbp = 6'd38;  6'd47: cbp = 6'd41;
      default: cbp = 6'd0;
    endcase
    return cbp;
  endfunction

  // codeNum -> coded_block_pattern for Inter macroblocks.
  function automatic logic [5:0] me_cbp_inter(input logic [5:0] code);
    logic [5:0] cbp;
    case (code)
      6'd0:  cbp = 6'd0;   6'd1:  cbp = 6'd16;  6'd2:  cbp = 6'd1;   6'd3:  cbp = 6'd2;
      6'd4:  cbp = 6'd4;   6'd5:  cbp = 6'd8;   6'd6:  cbp = 6'd32;  6'd7:  cbp = 6'd3;
      6'd8:  cbp = 6'd5;   6'd9:  cbp = 6'd10;  6'd10: cbp = 6'd12;  6'd11: cbp = 6'd15;
      6'd12: cbp = 6'd47;  6'd13: cbp = 6'd7;   6'd14: cbp = 6'd11;  6'd15: cbp = 6'd13;
      6'd16: cbp = 6'd14;  6'd17: cbp = 6'd6;   6'd18: cbp = 6'd9;   6'd19: cbp = 6'd31;
      6'd20: cbp = 6'd35;  6'd21: cbp = 6'd37;  6'd22: cbp = 6'd42;  6'd23: cbp = 6'd44;
      6'd24: cbp = 6'd33;  6'd25: cbp = 6'd34;  6'd26: cbp = 6'd36;  6'd27: cbp = 6'd40;
      6'd28: cbp = 6'd39;  6'd29: cbp = 6'd43;  6'd30: cbp = 6'd45;  6'd31: cbp = 6'd46;
      6'd32: cbp = 6'd17;  6'd33: cbp = 6'd18;  6'd34: cbp = 6'd20;  6'd35: cbp = 6'd24;
      6'd36: cbp = 6'd19;  6'd37: cbp = 6'd21;  6'd38: cbp = 6'd26;  6'd39: cbp = 6'd28;
      6'd40: cbp = 6'd23;  6'd41: cbp = 6'd27;  6'd42: cbp = 6'd29;  6'd43: cbp = 6'd30;
      6'd44: cbp = 6'd22;  6'd45: cbp = 6'd25;  6'd46: cbp = 6'd38;  6'd47: cbp = 6'd41;
      default: cbp = 6'd0;
    endcase
    return cbp;
  endfunction

endpackage

// File: rtl/exp_golomb_bitbuf.sv
// Purpose : MSB-aligned bit buffer of 2*WORD_W bits; words append below the
//           bits already held, consumption shifts the head out.
// Latency : an appended word is visible on peek the cycle after acceptance.
// Backpr. : in_ready drops while more than WORD_W bits are held.
// Ports   : in_data/in_valid/in_ready word input; cons_en/cons_len drop bits
//           from the head; peek = oldest WORD_W bits; cnt = bits held.
module exp_golomb_bitbuf
  import exp_golomb_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int CNT_W  = $clog2(2*WORD_W+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              cons_en,
  input  logic [LEN_W-1:0]  cons_len,
  output logic [WORD_W-1:0] peek,
  output logic [CNT_W-1:0]  cnt
);

  localparam int BUF_W = 2*WORD_W;

  logic [BUF_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cons_amt, cnt_left;
  logic             accept;

  assign in_ready = (cnt_q <= CNT_W'(WORD_W));
  assign accept   = in_valid && in_ready;

  // Consume first, then place the new word directly after the surviving
  // bits. Bits below the valid region are always zero, so OR is safe.
  always_comb begin
    cons_amt = cons_en ? CNT_W'(cons_len) : '0;
    cnt_left = cnt_q - cons_amt;
    bits_d   = bits_q << cons_amt;
    cnt_d    = cnt_left;
    if (accept) begin
      bits_d = bits_d | ({in_data, {WORD_W{1'b0}}} >> cnt_left);
      cnt_d  = cnt_left + CNT_W'(WORD_W);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q <= '0;
      cnt_q  <= '0;
    end else begin
      bits_q <= bits_d;
      cnt_q  <= cnt_d;
    end
  end

  assign peek = bits_q[BUF_W-1 -: WORD_W];
  assign cnt  = cnt_q;

endmodule

// File: rtl/exp_golomb_parser.sv
// Purpose : decodes one ue/se/te/me/u(n) syntax element per request from an
//           MSB-first bitstream held in exp_golomb_bitbuf.
// Latency : 2 cycles request-to-result when enough bits are already buffered.
// Backpr. : result held in OUT until res_ready; words accepted in every state.
// Ports   : in_* word stream; req_* decode request (mode, n, te max, me table);
//           res_* registered result with bits consumed and error flag;
//           bit_pos = running count of consumed bits (wraps at 2^32).
module exp_golomb_parser
  import exp_golomb_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int MAX_LZ = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_W-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_mode,
  input  logic [4:0]           req_nbits,
  input  logic [2:0]           req_te_max,
  input  logic                 req_intra,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [MAX_LZ+1:0]    res_value,
  output logic [3:0]           res_cbp_luma,
  output logic [1:0]           res_cbp_chroma,
  output logic [LEN_W-1:0]     res_len,
  output logic                 res_err,
  output logic [31:0]          bit_pos
);

  localparam int VAL_W = MAX_LZ + 2;
  localparam int WIN   = 2*MAX_LZ + 1;
  localparam int CNT_W = $clog2(2*WORD_W+1);
  localparam int U_MAX = (WORD_W < VAL_W) ? WORD_W : VAL_W;

  if (2*MAX_LZ+1 > WORD_W) begin : g_param_check
    $error("exp_golomb_parser: 2*MAX_LZ+1 must not exceed WORD_W");
  end

  // ---------------------------------------------------------------- buffer
  logic [WORD_W-1:0] peek;
  logic [CNT_W-1:0]  cnt;
  logic              cons_en;
  logic [LEN_W-1:0]  dec_len;

  exp_golomb_bitbuf #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_bitbuf (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cons_en  (cons_en),
    .cons_len (dec_len),
    .peek     (peek),
    .cnt      (cnt)
  );

  // ------------------------------------------------------- latched request
  eg_state_e  state_q;
  logic [2:0] mode_q;
  logic [4:0] nbits_q;
  logic [2:0] te_max_q;
  logic       intra_q;

  // ---------------------------------------------------------------- decode
  logic [WIN-1:0]   win;
  logic [5:0]       lz, lz_c;
  logic             lz_ok;
  logic [WIN-1:0]   sh, sfx_mask;
  logic [VAL_W-1:0] code, se_val;
  logic [LEN_W-1:0] ue_len;
  logic             te_bit;
  logic [5:0]       cbp;
  logic             nbits_ok;
  logic [VAL_W-1:0] dec_val;
  logic [3:0]       dec_luma;
  logic [1:0]       dec_chroma;
  logic             dec_err;
  logic [CNT_W-1:0] need;
  logic             have_bits;

  assign win      = peek[WORD_W-1 -: WIN];
  assign nbits_ok = (nbits_q != 5'd0) && (32'(nbits_q) <= U_MAX);

  always_comb begin
    // Leading-zero count over the first MAX_LZ+1 bits; MAX_LZ+1 means the
    // prefix is too long to be a legal code in this configuration.
    lz = 6'(MAX_LZ + 1);
    for (int i = MAX_LZ; i >= 0; i--) begin
      if (win[WIN-1-i]) lz = 6'(i);
    end
    lz_ok = (lz <= 6'(MAX_LZ));
    lz_c  = lz_ok ? lz : 6'd0;

    // Right-align the whole 2*lz+1 code, then keep its lz-bit suffix.
    sh       = win >> (WIN - 1 - 2*lz_c);
    sfx_mask = ~({WIN{1'b1}} << lz_c);
    code     = (VAL_W'(1) << lz_c) - VAL_W'(1) + VAL_W'(sh & sfx_mask);
    ue_len   = LEN_W'(2*lz_c + 1);

    if (code[0]) se_val = (code + VAL_W'(1)) >> 1;
    else         se_val = VAL_W'(0) - (code >> 1);

    te_bit = ~win[WIN-1];
    cbp    = intra_q ? me_cbp_intra(6'(code)) : me_cbp_inter(6'(code));

    dec_val    = '0;
    dec_len    = '0;
    dec_luma   = '0;
    dec_chroma = '0;
    dec_err    = 1'b0;
    case (mode_q)
      MODE_UE: begin
        if (lz_ok) begin
          dec_val = code;
          dec_len = ue_len;
        end else dec_err = 1'b1;
      end
      MODE_SE: begin
        if (lz_ok) begin
          dec_val = se_val;
          dec_len = ue_len;
        end else dec_err = 1'b1;
      end
      MODE_TE: begin
        if (te_max_q > 3'd1) begin
          if (lz_ok) begin
            dec_val = code;
            dec_len = ue_len;
          end else dec_err = 1'b1;
        end else begin
          dec_val = VAL_W'(te_bit);
          dec_len = LEN_W'(1);
        end
      end
      MODE_ME: begin
        if (lz_ok && (32'(code) <= ME_MAX_CODE)) begin
          dec_val    = code;
          dec_len    = ue_len;
          dec_luma   = cbp[3:0];
          dec_chroma = cbp[5:4];
        end else dec_err = 1'b1;
      end
      MODE_UN: begin
        if (nbits_ok) begin
          dec_val = VAL_W'(peek >> (WORD_W - 32'(nbits_q)));
          dec_len = LEN_W'(nbits_q);
        end else dec_err = 1'b1;
      end
      default: dec_err = 1'b1;
    endcase
  end

  // Bits that must be buffered before the decode above is trustworthy.
  // A malformed u(n) request needs none; it resolves to an error at once.
  always_comb begin
    case (mode_q)
      MODE_UN: need = nbits_ok ? CNT_W'(nbits_q) : '0;
      MODE_TE: need = (te_max_q <= 3'd1) ? CNT_W'(1) : CNT_W'(WIN);
      default: need = CNT_W'(WIN);
    endcase
  end

  assign have_bits = (cnt >= need);
  assign cons_en   = (state_q == ST_WAIT) && have_bits;
  assign req_ready = (state_q == ST_IDLE);

  // ------------------------------------------------------------------ FSM
  logic [VAL_W-1:0] res_value_q;
  logic [3:0]       res_luma_q;
  logic [1:0]       res_chroma_q;
  logic [LEN_W-1:0] res_len_q;
  logic             res_err_q;
  logic             res_valid_q;
  logic [31:0]      bit_pos_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= '0;
      nbits_q      <= '0;
      te_max_q     <= '0;
      intra_q      <= 1'b0;
      res_value_q  <= '0;
      res_luma_q   <= '0;
      res_chroma_q <= '0;
      res_len_q    <= '0;
      res_err_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      bit_pos_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            mode_q   <= req_mode;
            nbits_q  <= req_nbits;
            te_max_q <= req_te_max;
            intra_q  <= req_intra;
            state_q  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (have_bits) begin
            res_value_q  <= dec_val;
            res_luma_q   <= dec_luma;
            res_chroma_q <= dec_chroma;
            res_len_q    <= dec_len;
            res_err_q    <= dec_err;
            res_valid_q  <= 1'b1;
            bit_pos_q    <= bit_pos_q + 32'(dec_len);
            state_q      <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign res_valid      = res_valid_q;
  assign res_value      = res_value_q;
  assign res_cbp_luma   = res_luma_q;
  assign res_cbp_chroma = res_chroma_q;
  assign res_len        = res_len_q;
  assign res_err        = res_err_q;
  assign bit_pos        = bit_pos_q;

endmodule
